// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-qualified reset generator releasing NCH active-low
// resets in staged order after a programmable hold time.
module reset_sequencer #(
  parameter int NCH       = 4,
  parameter int HOLD_CYC  = 100,
  parameter int GAP_CYC   = 16,
  parameter int LOCK_FILT = 8,
  parameter int CNT_W     = 8
) (
  input  logic           CLK,
  input  logic           RST_X,
  input  logic           LOCKED,
  input  logic           SOFT_RST,
  output logic [NCH-1:0] RST_X_O,
  output logic           READY
);
  localparam int IDX_W = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {WAIT_LOCK, STRETCH, RELEASE, RUN} state_t;
  state_t state, state_n;
  logic sync_a, lock_s;
  logic [CNT_W-1:0] cnt, cnt_n, lim;
  logic [IDX_W-1:0] idx, idx_n;
  logic [NCH-1:0] rst_o_n, shifted;
  logic ready_n;
  // Shifting a 1 in from the bottom keeps the outputs thermometer-coded.
  assign shifted = NCH'({RST_X_O, 1'b1});
  assign lim = state == STRETCH ? CNT_W'(HOLD_CYC - 1) : CNT_W'(GAP_CYC - 1);
  always_ff @(posedge CLK)
    if (!RST_X) begin
      sync_a  <= 1'b0;
      lock_s  <= 1'b0;
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      RST_X_O <= '0;
      READY   <= 1'b0;
    end else begin
      sync_a  <= LOCKED;
      lock_s  <= sync_a;
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      RST_X_O <= rst_o_n;
      READY   <= ready_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    rst_o_n = RST_X_O;
    ready_n = READY;
    if (state != WAIT_LOCK && (!lock_s || SOFT_RST)) begin
      state_n = lock_s ? STRETCH : WAIT_LOCK;
      cnt_n   = '0;
      idx_n   = '0;
      rst_o_n = '0;
      ready_n = 1'b0;
    end else
      case (state)
        WAIT_LOCK: begin
          cnt_n = lock_s ? cnt + 1'b1 : '0;
          if (lock_s && cnt == CNT_W'(LOCK_FILT - 1)) begin
            state_n = STRETCH;
            cnt_n   = '0;
          end
        end
        STRETCH, RELEASE: begin
          cnt_n = cnt + 1'b1;
          if (cnt == lim) begin
            cnt_n   = '0;
            rst_o_n = shifted;
            ready_n = &shifted;
            state_n = &shifted ? RUN : RELEASE;
            idx_n   = state == RELEASE ? idx + 1'b1 : idx;
          end
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: checks a default and a minimal (all-ones) instance
// against a timeline model plus hand-computed release edges.
module tb_reset_sequencer;
  logic CLK = 1'b0;
  logic RST_X = 1'b0;
  logic LOCKED = 1'b1;
  logic SOFT_RST = 1'b0;
  logic [3:0] o0;
  logic [0:0] o1;
  logic r0, r1;
  int total = 0;
  int passed = 0;
  int e = 0;
  bit m_s1 = 0;
  bit m_s2 = 0;
  bit m_seq [2] = '{0, 0};
  int m_run [2] = '{0, 0};
  int m_t [2] = '{0, 0};
  int p_nch [2] = '{4, 1};
  int p_hold [2] = '{100, 1};
  int p_gap [2] = '{16, 1};
  int p_lf [2] = '{8, 1};

  reset_sequencer dut0 (
    .CLK(CLK), .RST_X(RST_X), .LOCKED(LOCKED), .SOFT_RST(SOFT_RST),
    .RST_X_O(o0), .READY(r0)
  );
  reset_sequencer #(.NCH(1), .HOLD_CYC(1), .GAP_CYC(1), .LOCK_FILT(1), .CNT_W(2)) dut1 (
    .CLK(CLK), .RST_X(RST_X), .LOCKED(LOCKED), .SOFT_RST(SOFT_RST),
    .RST_X_O(o1), .READY(r1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
  endtask

  // Model: channels released = time since hold start, measured in gaps.
  function automatic int exp_n(input int k);
    int n;
    if (!m_seq[k] || m_t[k] < p_hold[k]) return 0;
    n = 1 + (m_t[k] - p_hold[k]) / p_gap[k];
    return n > p_nch[k] ? p_nch[k] : n;
  endfunction

  task automatic model_step();
    if (!RST_X) begin
      m_s1 = 0;
      m_s2 = 0;
      for (int k = 0; k < 2; k++) begin
        m_seq[k] = 0;
        m_run[k] = 0;
        m_t[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (m_seq[k]) begin
          if (!m_s2) begin
            m_seq[k] = 0;
            m_run[k] = 0;
          end else if (SOFT_RST) m_t[k] = 0;
          else m_t[k]++;
        end else begin
          m_run[k] = m_s2 ? m_run[k] + 1 : 0;
          if (m_run[k] == p_lf[k]) begin
            m_seq[k] = 1;
            m_t[k] = 0;
            m_run[k] = 0;
          end
        end
      m_s2 = m_s1;
      m_s1 = LOCKED;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    chk("out0", int'(o0), (1 << exp_n(0)) - 1);
    chk("ready0", int'(r0), int'(exp_n(0) == 4));
    chk("out1", int'(o1), (1 << exp_n(1)) - 1);
    chk("ready1", int'(r1), int'(exp_n(1) == 1));
    chk("therm0", int'(((int'(o0) + 1) & int'(o0)) == 0), 1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
    e += n;
  endtask

  task automatic to(input int target);
    step(target - e);
  endtask

  // e counts edges from the edge where the synchronised lock first reads high.
  task automatic restart(input int low_cycles);
    RST_X = 1'b0;
    LOCKED = 1'b1;
    SOFT_RST = 1'b0;
    step(low_cycles);
    RST_X = 1'b1;
    step(2);
    e = 0;
  endtask

  initial begin
    step(5);
    chk("reset_out0", int'(o0), 0);
    chk("reset_ready0", int'(r0), 0);
    chk("reset_out1", int'(o1), 0);
    chk("reset_ready1", int'(r1), 0);
    RST_X = 1'b1;
    step(2);
    e = 0;
    to(1);   chk("min_pre", int'(o1), 0);
    to(2);   chk("min_out", int'(o1), 1); chk("min_ready", int'(r1), 1);
    to(107); chk("seq_107", int'(o0), 0);
    to(108); chk("seq_108", int'(o0), 1); chk("seq_rdy108", int'(r0), 0);
    to(123); chk("seq_123", int'(o0), 1);
    to(124); chk("seq_124", int'(o0), 3);
    to(140); chk("seq_140", int'(o0), 7);
    to(155); chk("seq_155", int'(o0), 7); chk("seq_rdy155", int'(r0), 0);
    to(156); chk("seq_156", int'(o0), 15); chk("seq_rdy156", int'(r0), 1);
    to(170); LOCKED = 1'b0;
    to(172); chk("loss_172", int'(o0), 15);
    to(173); chk("loss_173", int'(o0), 0); chk("loss_rdy", int'(r0), 0);
    LOCKED = 1'b1;
    to(175); e = 0;
    to(107); chk("relock_107", int'(o0), 0);
    to(108); chk("relock_108", int'(o0), 1);
    to(156); chk("relock_156", int'(o0), 15); chk("relock_rdy", int'(r0), 1);
    to(160); SOFT_RST = 1'b1;
    to(161); chk("soft_161", int'(o0), 0); chk("soft_rdy", int'(r0), 0);
    SOFT_RST = 1'b0;
    to(260); chk("soft_260", int'(o0), 0);
    to(261); chk("soft_261", int'(o0), 1);
    to(308); chk("soft_308", int'(o0), 7);
    to(309); chk("soft_309", int'(o0), 15); chk("soft_rdy309", int'(r0), 1);
    restart(3);
    to(3); LOCKED = 1'b0;
    to(4); LOCKED = 1'b1;
    to(108); chk("glitch_108", int'(o0), 0);
    to(113); chk("glitch_113", int'(o0), 0);
    to(114); chk("glitch_114", int'(o0), 1);
    restart(3);
    to(130); LOCKED = 1'b0;
    to(131); LOCKED = 1'b1;
    to(132); SOFT_RST = 1'b1;
    to(133); chk("both_133", int'(o0), 0); chk("both_rdy", int'(r0), 0);
    SOFT_RST = 1'b0;
    to(240); chk("both_240", int'(o0), 0);
    to(241); chk("both_241", int'(o0), 1);
    to(261); RST_X = 1'b0;
    to(262); chk("rstx_262", int'(o0), 0); chk("rstx_out1", int'(o1), 0);
    to(263); RST_X = 1'b1;
    to(265); e = 0;
    to(107); chk("rstx_107", int'(o0), 0);
    to(108); chk("rstx_108", int'(o0), 1);
    for (int i = 0; i < 4000; i++) begin
      LOCKED = $urandom_range(0, 999) >= 4;
      SOFT_RST = $urandom_range(0, 999) < 5;
      step(1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
